// File: rtl/pixel_stream_rx.sv
// ============================================================================
// pixel_stream_rx : framed pixel-stream receiver writing into a framebuffer.
// Optional error counter enabled by macro PIXEL_RX_ERR_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef COLOR_WIDTH
`define COLOR_WIDTH 8
`endif

module pixel_stream_rx #(
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480,
   parameter int ADDR_WIDTH   = 19
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [`COLOR_WIDTH-1:0] shade_in,
   input  logic                    valid_in,
   input  logic                    sof_in,
   input  logic                    eol_in,
   output logic                    ready_out,
   output logic [`COLOR_WIDTH-1:0] wr_data,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic                    wr_en,
   input  logic                    wr_ready,
   output logic                    frame_done,
   output logic                    sync_err,
   output logic [15:0]             err_count
);

   localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
   localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
   localparam logic [XW-1:0] C_X_LAST = XW'(FRAME_WIDTH - 1);
   localparam logic [YW-1:0] C_Y_LAST = YW'(FRAME_HEIGHT - 1);

   typedef enum logic [0:0] {
      S_WAIT_SOF = 1'b0,
      S_IN_FRAME = 1'b1
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [XW-1:0]           r_x, w_x_nxt;
   logic [YW-1:0]           r_y, w_y_nxt;
   logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
   logic                    w_xfer;
   logic                    w_wr;
   logic [ADDR_WIDTH-1:0]   w_wr_addr;
   logic                    w_last;
   logic                    w_err;

   logic                    r_wr_en;
   logic [`COLOR_WIDTH-1:0] r_wr_data;
   logic [ADDR_WIDTH-1:0]   r_wr_addr;
   logic                    r_frame_done;
   logic                    r_sync_err;

   // Single output register: a new beat may enter whenever the held write retires.
   assign ready_out = !r_wr_en || wr_ready;
   assign w_xfer    = valid_in && ready_out;

   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_addr_nxt  = r_addr;
      w_wr        = 1'b0;
      w_wr_addr   = r_addr;
      w_last      = 1'b0;
      w_err       = 1'b0;
      if (w_xfer) begin
         if (sof_in) begin
            // A restart inside a frame is an error; sof+eol fails at x=0.
            w_err = (r_state == S_IN_FRAME) || eol_in;
            if (eol_in) begin
               w_state_nxt = S_WAIT_SOF;
               w_x_nxt     = '0;
               w_y_nxt     = '0;
            end else begin
               w_wr        = 1'b1;
               w_wr_addr   = '0;
               w_x_nxt     = XW'(1);
               w_y_nxt     = '0;
               w_addr_nxt  = ADDR_WIDTH'(1);
               w_state_nxt = S_IN_FRAME;
            end
         end else if (r_state == S_IN_FRAME) begin
            if (eol_in != (r_x == C_X_LAST)) begin
               w_err       = 1'b1;
               w_state_nxt = S_WAIT_SOF;
               w_x_nxt     = '0;
               w_y_nxt     = '0;
            end else begin
               w_wr       = 1'b1;
               w_addr_nxt = r_addr + ADDR_WIDTH'(1);
               if (r_x != C_X_LAST) begin
                  w_x_nxt = r_x + XW'(1);
               end else if (r_y != C_Y_LAST) begin
                  w_x_nxt = '0;
                  w_y_nxt = r_y + YW'(1);
               end else begin
                  w_last      = 1'b1;
                  w_x_nxt     = '0;
                  w_y_nxt     = '0;
                  w_state_nxt = S_WAIT_SOF;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_WAIT_SOF;
         r_x          <= '0;
         r_y          <= '0;
         r_addr       <= '0;
         r_wr_en      <= 1'b0;
         r_wr_data    <= '0;
         r_wr_addr    <= '0;
         r_frame_done <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_x          <= w_x_nxt;
         r_y          <= w_y_nxt;
         r_addr       <= w_addr_nxt;
         r_frame_done <= w_last;
         r_sync_err   <= w_err;
         if (w_wr) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= shade_in;
            r_wr_addr <= w_wr_addr;
         end else if (wr_ready) begin
            r_wr_en   <= 1'b0;
         end
      end
   end

   assign wr_en      = r_wr_en;
   assign wr_data    = r_wr_data;
   assign wr_addr    = r_wr_addr;
   assign frame_done = r_frame_done;
   assign sync_err   = r_sync_err;

`ifdef PIXEL_RX_ERR_COUNT_EN
   logic [15:0] r_err_count;

   // Counts alongside the sync_err pulse so both are visible in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_count <= '0;
      end else if (w_err && (r_err_count != 16'hFFFF)) begin
         r_err_count <= r_err_count + 16'd1;
      end
   end

   assign err_count = r_err_count;
`else
   assign err_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_stream_rx.sv
// ============================================================================
// tb_pixel_stream_rx : scoreboard bench for pixel_stream_rx (4x2 frame).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef COLOR_WIDTH
`define COLOR_WIDTH 8
`endif

module tb_pixel_stream_rx;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = 8;
   localparam int CW = `COLOR_WIDTH;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] shade_in;
   logic          valid_in, sof_in, eol_in;
   logic          ready_out;
   logic [CW-1:0] wr_data;
   logic [AW-1:0] wr_addr;
   logic          wr_en;
   logic          wr_ready;
   logic          frame_done, sync_err;
   logic [15:0]   err_count;

   pixel_stream_rx #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .shade_in(shade_in), .valid_in(valid_in),
      .sof_in(sof_in), .eol_in(eol_in), .ready_out(ready_out),
      .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en), .wr_ready(wr_ready),
      .frame_done(frame_done), .sync_err(sync_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] d;
      logic [AW-1:0] a;
      bit            last;
   } wr_t;

   wr_t wq[$];
   int  sync_pending = 0;
   int  checks = 0;
   int  errors = 0;
   bit  started = 0;
   bit  rand_ready = 0;
   int  force_cnt = 0;

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: frame position as a linear pixel index.
   bit in_frame = 0;
   int pos = 0;
   always @(negedge clk) begin
      if (rst) begin
         wq.delete();
         sync_pending = 0;
         in_frame     = 0;
         pos          = 0;
      end else if (valid_in && ready_out) begin
         if (sof_in) begin
            if (in_frame || eol_in) sync_pending++;
            if (eol_in) begin
               in_frame = 0;
            end else begin
               wq.push_back('{d: shade_in, a: '0, last: 1'b0});
               pos      = 1;
               in_frame = 1;
            end
         end else if (in_frame) begin
            if (eol_in != ((pos % W) == W - 1)) begin
               sync_pending++;
               in_frame = 0;
            end else begin
               wq.push_back('{d: shade_in, a: AW'(pos), last: (pos == W*H - 1)});
               if (pos == W*H - 1) in_frame = 0;
               else pos++;
            end
         end
      end
   end

   // Monitor: retires writes and pulses against the model's expectations.
   bit            seen_fd = 0;
   int            seen_err = 0;
   bit            prev_stall = 0;
   logic [CW-1:0] prev_d;
   logic [AW-1:0] prev_a;
   always @(negedge clk) begin
      wr_t e;
      bit  ok;
      if (rst || !started) begin
         seen_fd    = 0;
         seen_err   = 0;
         prev_stall = 0;
      end else begin
         chk(ready_out == (!wr_en || wr_ready), "ready_out", int'(ready_out), int'(!wr_en || wr_ready));
         chk(!(frame_done && sync_err), "fd_err_same_cycle", int'(frame_done && sync_err), 0);
         if (prev_stall)
            chk(wr_en && wr_data == prev_d && wr_addr == prev_a, "held_write", int'(wr_addr), int'(prev_a));
         if (sync_err) begin
            chk(sync_pending > 0, "sync_err_expected", sync_pending, 1);
            if (sync_pending > 0) sync_pending--;
            seen_err++;
`ifdef PIXEL_RX_ERR_COUNT_EN
            chk(err_count == 16'(seen_err), "err_count", int'(err_count), seen_err);
`else
            chk(err_count == 16'd0, "err_count", int'(err_count), 0);
`endif
         end
         if (frame_done) begin
            ok = wr_en && (wq.size() > 0) && !seen_fd;
            if (ok) ok = wq[0].last;
            chk(ok, "frame_done_place", int'(wr_addr), W*H - 1);
            seen_fd = 1;
         end
         if (wr_en && wr_ready) begin
            if (wq.size() == 0) begin
               chk(1'b0, "unexpected_write", int'(wr_addr), -1);
            end else begin
               e = wq.pop_front();
               chk(wr_addr == e.a, "wr_addr", int'(wr_addr), int'(e.a));
               chk(wr_data == e.d, "wr_data", int'(wr_data), int'(e.d));
               if (e.last) chk(seen_fd, "frame_done_missing", int'(seen_fd), 1);
            end
            seen_fd = 0;
         end
         prev_stall = wr_en && !wr_ready;
         prev_d     = wr_data;
         prev_a     = wr_addr;
      end
   end

   initial begin
      wr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (force_cnt > 0) begin
            wr_ready = 1'b0;
            force_cnt--;
         end else begin
            wr_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
         end
      end
   end

   task automatic send_beat(input int d, input bit s, input bit e);
      bit done = 0;
      shade_in = CW'(d);
      sof_in   = s;
      eol_in   = e;
      valid_in = 1'b1;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         done = ready_out;
         @(posedge clk);
         #1;
      end
      if (!done) chk(1'b0, "xfer_timeout", 0, 1);
      valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         valid_in = 1'b0;
         sof_in   = 1'($urandom);
         eol_in   = 1'($urandom);
         shade_in = CW'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clean_frame(input int base);
      for (int i = 0; i < W*H; i++) send_beat(base + i, i == 0, (i % W) == W - 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int gp;
      int r;
      bit s, e;
      rst = 1'b1; valid_in = 1'b0; sof_in = 1'b0; eol_in = 1'b0; shade_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(wr_en == 1'b0, "rst_wr_en", int'(wr_en), 0);
      chk(wr_addr == '0 && wr_data == '0, "rst_wr_bus", int'(wr_addr), 0);
      chk(!frame_done && !sync_err, "rst_pulses", int'(frame_done) + int'(sync_err), 0);
      chk(err_count == 16'd0, "rst_err_count", int'(err_count), 0);
      chk(ready_out == 1'b1, "rst_ready", int'(ready_out), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      started = 1;

      // beats before any sof are dropped silently
      for (int i = 0; i < 3; i++) send_beat(9, 0, 0);
      idle(2);
      // clean frame, then the same frame with a 3-cycle sink stall
      clean_frame(1);
      idle(2);
      for (int i = 0; i < W*H; i++) begin
         if (i == 3) force_cnt = 3;
         send_beat(i + 1, i == 0, (i % W) == W - 1);
      end
      idle(3);
      // eol too early on beat 3
      for (int i = 0; i < W*H; i++) send_beat(i + 1, i == 0, (i == 2) || (i % W) == W - 1);
      idle(2);
      // premature sof on beat 6, then 7 beats to finish the restarted frame
      for (int i = 0; i < 5; i++) send_beat(20 + i, i == 0, (i % W) == W - 1);
      for (int i = 0; i < W*H; i++) send_beat(40 + i, i == 0, (i % W) == W - 1);
      idle(2);
      // reset after beat 5
      for (int i = 0; i < 5; i++) send_beat(60 + i, i == 0, (i % W) == W - 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk(wr_en == 1'b0, "midrst_wr_en", int'(wr_en), 0);
      chk(err_count == 16'd0, "midrst_err_count", int'(err_count), 0);
      chk(!sync_err, "midrst_sync_err", int'(sync_err), 0);
      rst = 1'b0;
      clean_frame(80);
      idle(2);

      // randomized: mostly well-formed frames with occasional flag corruption
      rand_ready = 1;
      gp = 0;
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 10) begin
            idle($urandom_range(1, 3));
         end else begin
            s = (gp == 0);
            e = ((gp % W) == W - 1);
            if ($urandom_range(0, 99) < 6) s = ~s;
            if ($urandom_range(0, 99) < 6) e = ~e;
            send_beat($urandom_range(0, 255), s, e);
            gp = (gp + 1) % (W*H);
         end
      end
      rand_ready = 0;
      idle(10);
      chk(wq.size() == 0, "writes_drained", wq.size(), 0);
      chk(sync_pending == 0, "sync_err_drained", sync_pending, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pixel_stream_rx.md
PIXEL_STREAM_RX -- requirements
Module: pixel_stream_rx

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 640, pixels per line (>=2).
REQ-002 SHALL have parameter FRAME_HEIGHT, default 480, lines per frame (>=1).
REQ-003 SHALL have parameter ADDR_WIDTH, default 19, framebuffer word-address width (>= clog2(FRAME_WIDTH*FRAME_HEIGHT)).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port shade_in  input  `COLOR_WIDTH  incoming pixel value.
REQ-007 SHALL have port valid_in  input  1  pixel beat valid.
REQ-008 SHALL have port sof_in  input  1  beat is first pixel of frame.
REQ-009 SHALL have port eol_in  input  1  beat is last pixel of line.
REQ-010 SHALL have port ready_out  output  1  sink can accept beat; transfer = valid_in && ready_out.
REQ-011 SHALL have port wr_data  output  `COLOR_WIDTH  framebuffer write data.
REQ-012 SHALL have port wr_addr  output  ADDR_WIDTH  framebuffer write address = y*FRAME_WIDTH + x.
REQ-013 SHALL have port wr_en  output  1  write request valid.
REQ-014 SHALL have port wr_ready  input  1  framebuffer accepts write; write completes on wr_en && wr_ready.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse, complete frame received.
REQ-016 SHALL have port sync_err  output  1  one-cycle pulse, framing error detected.
REQ-017 SHALL have port err_count  output  16  accumulated framing errors.

Function
REQ-018 SHALL implement states WAIT_SOF and IN_FRAME with position counters x (0..FRAME_WIDTH-1), y (0..FRAME_HEIGHT-1).
REQ-019 SHALL hold the write in one output register; ready_out = !wr_en || wr_ready (combinational), giving full throughput without bubbles.
REQ-020 SHALL present each written beat on wr_en/wr_data/wr_addr exactly 1 cycle after its transfer; wr_* held stable while wr_en && !wr_ready.
REQ-021 SHALL compute wr_addr with an incrementing counter (no multiplier), reset to 0 on every frame start.
REQ-022 WAIT_SOF: accepted beats without sof_in SHALL be discarded (no write); beat with sof_in SHALL be written at address 0, state -> IN_FRAME.
REQ-023 IN_FRAME, x<FRAME_WIDTH-1, no flags: SHALL write at current address, x+1.
REQ-024 IN_FRAME, x==FRAME_WIDTH-1 with eol_in, y<FRAME_HEIGHT-1: SHALL write, x=0, y+1.
REQ-025 IN_FRAME, x==FRAME_WIDTH-1 with eol_in, y==FRAME_HEIGHT-1: SHALL write, pulse frame_done in the cycle that write's wr_en first asserts, state -> WAIT_SOF.
REQ-026 eol_in at x<FRAME_WIDTH-1, or no eol_in at x==FRAME_WIDTH-1: SHALL drop the beat, pulse sync_err next cycle, state -> WAIT_SOF.
REQ-027 sof_in while IN_FRAME: SHALL pulse sync_err (premature restart), write beat at address 0, restart x=1,y=0, stay IN_FRAME.
REQ-028 sof_in and eol_in on same beat: SHALL process sof first, then treat eol as REQ-026 error (beat dropped, -> WAIT_SOF).
REQ-029 SHALL ignore sof_in/eol_in/shade_in when no transfer occurs.
REQ-030 frame_done and sync_err SHALL never both assert in the same cycle.

Reset
REQ-031 On rst SHALL set state WAIT_SOF, x=0, y=0, address 0, wr_en=0, wr_data=0, wr_addr=0, frame_done=0, sync_err=0, err_count=0; ready_out=1 after reset.
REQ-032 rst mid-frame SHALL discard the pending write and partial frame without a sync_err pulse.

Configuration
REQ-033 With macro PIXEL_RX_ERR_COUNT_EN defined, err_count SHALL increment on each sync_err pulse, saturating at 16'hFFFF.
REQ-034 Without PIXEL_RX_ERR_COUNT_EN, err_count SHALL be constant 0 and no counter logic generated; sync_err unaffected.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=2)
REQ-035 Clean frame, 8 beats, values 1..8, sof on beat 1, eol on beats 4,8, wr_ready=1 -> writes addr 0..7 data 1..8, one frame_done with addr 7, sync_err never.
REQ-036 Same frame, wr_ready low 3 cycles mid-frame -> ready_out low those cycles, no beat lost/duplicated, addresses 0..7 in order.
REQ-037 eol on beat 3 -> beat 3 not written, sync_err one pulse, beats 4..8 discarded until next sof, err_count=1 (with macro).
REQ-038 sof on beat 6 of a frame -> sync_err pulse, beat 6 written to addr 0, next 7 beats complete frame at addr 1..7, frame_done once.
REQ-039 rst asserted after beat 5 -> wr_en=0 next cycle, err_count=0, following clean frame writes addr 0..7 normally.
REQ-040 Beats before any sof (values 9,9,9) -> no writes, no sync_err.
